lfsr_prbs_checker: RTL and testbench

- Receive-side companion to the 128-bit XNOR LFSR generator used for pseudo-random pattern and keystream generation.
- Consumes the generator's serial output bit stream, which is bit 1 (the newly inserted feedback bit) of each generator state.
- Self-synchronises a local 128-bit LFSR to the stream, then predicts every following bit and counts mismatches.
- Declares lock and loss-of-lock, so links and test-pattern paths carrying generator output can be verified in hardware.

---
 rtl/lfsr_prbs_checker.sv | 161 ++++++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker
// Receive-side checker for the 128-bit XNOR LFSR pattern generator.
// The received serial stream (the generator's newly inserted bit 1 per step)
// is first loaded straight into a local copy of the generator register.
// Once 128 bits are in, the checker free-runs its own LFSR and compares
// each received bit against the prediction.
//
// Handshake: i_Bit is consumed only on cycles where i_Bit_DV is high.
// There is no backpressure, and gaps of any length are allowed in every
// state. i_Clear_Count is the one input that acts on every cycle,
// regardless of i_Bit_DV.
//
// Error handling: in CHECK the local register shifts in its own prediction,
// never the received bit. A corrupted bit on the line is therefore counted
// once and does not pollute later predictions. Errors are also accumulated
// per window of WINDOW checked bits. Reaching LOSS_THRESH errors inside one
// window drops lock and forces a fresh 128-bit refill from the stream.
//
// State encoding on o_State: 0 = IDLE, 1 = FILL, 2 = CHECK.

module lfsr_prbs_checker #(
   parameter int NUM_BITS    = 128,
   parameter int ERR_BITS    = 16,
   parameter int WINDOW      = 256,
   parameter int LOSS_THRESH = 8
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_Bit_DV,
   input  logic                i_Bit,
   input  logic                i_Clear_Count,
   output logic                o_Locked,
   output logic                o_Err_Pulse,
   output logic [ERR_BITS-1:0] o_Err_Count,
   output logic                o_Lockup,
   output logic [1:0]          o_State
);

   // Counter widths sized so each counter can hold its terminal value.
   localparam int FILL_W = $clog2(NUM_BITS + 1);
   localparam int WIN_W  = $clog2(WINDOW + 1);
   localparam int WE_W   = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(NUM_BITS - 1);
   localparam logic [FILL_W-1:0]   FILL_ONE  = FILL_W'(1);
   localparam logic [WIN_W-1:0]    WIN_LAST  = WIN_W'(WINDOW - 1);
   localparam logic [WIN_W-1:0]    WIN_ONE   = WIN_W'(1);
   localparam logic [WE_W-1:0]     LOSS_LIM  = WE_W'(LOSS_THRESH);
   localparam logic [ERR_BITS-1:0] ERR_MAX   = {ERR_BITS{1'b1}};
   localparam logic [ERR_BITS-1:0] ERR_ONE   = ERR_BITS'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t              state;
   logic [NUM_BITS:1]   exp_reg;
   logic [FILL_W-1:0]   fill_cnt;
   logic [WIN_W-1:0]    win_cnt;
   logic [WE_W-1:0]     win_err;

   logic                fb;
   logic                mismatch;
   logic [WE_W-1:0]     win_err_inc;
   logic                loss;

   // Prediction of the next stream bit, plus this cycle's error and
   // loss-of-lock decision.
   always_comb begin
      fb = exp_reg[100] ~^ exp_reg[95] ~^ exp_reg[50] ~^ exp_reg[13]
           ~^ exp_reg[10] ~^ exp_reg[5] ~^ exp_reg[3] ~^ exp_reg[1];
      mismatch    = 1'b0;
      win_err_inc = win_err;
      loss        = 1'b0;
      if (i_Bit_DV && (state == ST_CHECK)) begin
         mismatch = (i_Bit != fb);
      end
      // The current bit's error counts toward the window before any
      // rollover clear, so it can be the one that trips loss of lock.
      win_err_inc = win_err + {{(WE_W-1){1'b0}}, mismatch};
      loss        = mismatch && (win_err_inc >= LOSS_LIM);
   end

   // Main FSM: synchronisation fill, checking, window bookkeeping,
   // and registered status outputs.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= ST_IDLE;
         exp_reg     <= '0;
         fill_cnt    <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         o_Locked    <= 1'b0;
         o_Err_Pulse <= 1'b0;
         o_Lockup    <= 1'b0;
      end else begin
         o_Err_Pulse <= 1'b0;
         // Reflects the register as it stands this cycle. In CHECK this
         // means a stuck-high stream has been accepted as the pattern.
         o_Lockup    <= (state != ST_IDLE) && (&exp_reg);
         if (i_Bit_DV) begin
            case (state)
               ST_IDLE: begin
                  exp_reg  <= {exp_reg[NUM_BITS-1:1], i_Bit};
                  fill_cnt <= FILL_ONE;
                  state    <= ST_FILL;
               end
               ST_FILL: begin
                  exp_reg  <= {exp_reg[NUM_BITS-1:1], i_Bit};
                  fill_cnt <= fill_cnt + FILL_ONE;
                  if (fill_cnt == FILL_LAST) begin
                     state    <= ST_CHECK;
                     o_Locked <= 1'b1;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end
               end
               ST_CHECK: begin
                  // Shift in the prediction so a line error cannot propagate.
                  exp_reg     <= {exp_reg[NUM_BITS-1:1], fb};
                  o_Err_Pulse <= mismatch;
                  if (loss) begin
                     state    <= ST_FILL;
                     fill_cnt <= '0;
                     win_cnt  <= '0;
                     win_err  <= '0;
                     o_Locked <= 1'b0;
                  end else if (win_cnt == WIN_LAST) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + WIN_ONE;
                     win_err <= win_err_inc;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  o_Locked <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating total error counter. A clear in the same cycle as an
   // error wins.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Err_Count <= '0;
      end else if (i_Clear_Count) begin
         o_Err_Count <= '0;
      end else if (mismatch && (o_Err_Count != ERR_MAX)) begin
         o_Err_Count <= o_Err_Count + ERR_ONE;
      end
   end

   assign o_State = state;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb_lfsr_prbs_checker
// Directed bench for lfsr_prbs_checker. A reference 128-bit XNOR generator
// produces the stream, and selected bits are inverted to inject errors.
// The DUT uses a 4-bit error counter so that saturation is reachable.

module tb_lfsr_prbs_checker;

   localparam int ERR_BITS = 4;

   logic                clk = 1'b0;
   logic                i_Rst;
   logic                i_Bit_DV;
   logic                i_Bit;
   logic                i_Clear_Count;
   logic                o_Locked;
   logic                o_Err_Pulse;
   logic [ERR_BITS-1:0] o_Err_Count;
   logic                o_Lockup;
   logic [1:0]          o_State;

   int n_cmp  = 0;
   int n_bad  = 0;
   int pulses = 0;

   logic [128:1] g;

   lfsr_prbs_checker #(
      .NUM_BITS    (128),
      .ERR_BITS    (ERR_BITS),
      .WINDOW      (256),
      .LOSS_THRESH (8)
   ) dut (
      .i_Clk         (clk),
      .i_Rst         (i_Rst),
      .i_Bit_DV      (i_Bit_DV),
      .i_Bit         (i_Bit),
      .i_Clear_Count (i_Clear_Count),
      .o_Locked      (o_Locked),
      .o_Err_Pulse   (o_Err_Pulse),
      .o_Err_Count   (o_Err_Count),
      .o_Lockup      (o_Lockup),
      .o_State       (o_State)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed run still active, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference generator: next output bit, generator state advanced
   task automatic gen_bit(output logic b);
      logic f;
      f = g[100] ~^ g[95] ~^ g[50] ~^ g[13] ~^ g[10] ~^ g[5] ~^ g[3] ~^ g[1];
      g = {g[127:1], f};
      b = f;
   endtask

   // one clock: drive at negedge, observe 1 time unit after the rising edge
   task automatic step(input logic dv, input logic b);
      @(negedge clk);
      i_Bit_DV = dv;
      i_Bit    = b;
      @(posedge clk);
      #1;
      if (o_Err_Pulse === 1'b1) pulses++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_Rst         = 1'b1;
      i_Bit_DV      = 1'b0;
      i_Bit         = 1'b0;
      i_Clear_Count = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      i_Rst  = 1'b0;
      g      = 128'h1;
      pulses = 0;
   endtask

   initial begin
      logic b;
      int   valid;
      int   iters;

      i_Rst         = 1'b1;
      i_Bit_DV      = 1'b0;
      i_Bit         = 1'b0;
      i_Clear_Count = 1'b0;
      g             = 128'h1;

      // reset state
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("rst_state",  o_State,     0);
      check("rst_locked", o_Locked,    0);
      check("rst_count",  o_Err_Count, 0);
      check("rst_pulse",  o_Err_Pulse, 0);
      check("rst_lockup", o_Lockup,    0);

      // clean lock, 300 bits
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         gen_bit(b);
         step(1'b1, b);
         if (i == 1)   check("fill_state", o_State, 1);
         if (i == 127) check("lock_before_128", o_Locked, 0);
         if (i == 128) begin
            check("lock_after_128", o_Locked, 1);
            check("state_check", o_State, 2);
         end
      end
      check("clean_count",  o_Err_Count, 0);
      check("clean_pulses", pulses, 0);

      // single error at bit 150
      do_reset();
      for (int i = 1; i <= 400; i++) begin
         gen_bit(b);
         step(1'b1, b ^ (i == 150));
         if (i == 150) check("single_pulse_at", o_Err_Pulse, 1);
         if (i == 151) check("single_pulse_after", o_Err_Pulse, 0);
      end
      check("single_count",  o_Err_Count, 1);
      check("single_pulses", pulses, 1);
      check("single_locked", o_Locked, 1);

      // loss of lock: errors at 140,145,...,175
      do_reset();
      for (int i = 1; i <= 320; i++) begin
         gen_bit(b);
         step(1'b1, b ^ (i >= 140 && i <= 175 && ((i - 140) % 5) == 0));
         if (i == 170) check("loss_locked_7err", o_Locked, 1);
         if (i == 175) begin
            check("loss_unlocked", o_Locked, 0);
            check("loss_state_fill", o_State, 1);
         end
         if (i == 302) check("relock_before", o_Locked, 0);
         if (i == 303) check("relock_at", o_Locked, 1);
      end
      check("loss_count",  o_Err_Count, 8);
      check("loss_locked", o_Locked, 1);

      // window rollover: 7 errors at 378..384 (window 1), 7 at 385..391 (window 2)
      do_reset();
      for (int i = 1; i <= 700; i++) begin
         gen_bit(b);
         step(1'b1, b ^ (i >= 378 && i <= 391));
         if (i == 384) check("win1_end_locked", o_Locked, 1);
         if (i == 391) check("win2_locked", o_Locked, 1);
      end
      check("win_count",  o_Err_Count, 14);
      check("win_pulses", pulses, 14);
      check("win_locked", o_Locked, 1);

      // saturation with a random stream after lock
      do_reset();
      for (int i = 1; i <= 128; i++) begin
         gen_bit(b);
         step(1'b1, b);
      end
      for (int i = 1; i <= 600; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)));
      end
      check("sat_count", o_Err_Count, 15);
      i_Clear_Count = 1'b1;
      step(1'b0, 1'b0);
      i_Clear_Count = 1'b0;
      check("clear_count", o_Err_Count, 0);

      // clear concurrent with an error
      do_reset();
      for (int i = 1; i <= 128; i++) begin
         gen_bit(b);
         step(1'b1, b);
      end
      gen_bit(b);
      i_Clear_Count = 1'b1;
      step(1'b1, ~b);
      i_Clear_Count = 1'b0;
      check("clr_err_pulse", o_Err_Pulse, 1);
      check("clr_err_count", o_Err_Count, 0);
      gen_bit(b);
      step(1'b1, ~b);
      check("post_clr_count", o_Err_Count, 1);
      gen_bit(b);
      step(1'b1, b);
      check("post_clr_pulse", o_Err_Pulse, 0);

      // random DV gaps
      do_reset();
      valid = 0;
      iters = 0;
      while (valid < 128 && iters < 2000) begin
         iters++;
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(b);
            step(1'b1, b);
            valid++;
            if (valid == 127) check("gap_lock_before", o_Locked, 0);
            if (valid == 128) check("gap_lock_at", o_Locked, 1);
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)));
         end
      end
      check("gap_valid_bits", valid, 128);
      for (int i = 1; i <= 80; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(b);
            step(1'b1, b);
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)));
         end
      end
      check("gap_count",  o_Err_Count, 0);
      check("gap_pulses", pulses, 0);
      check("gap_locked", o_Locked, 1);

      // reset mid-CHECK with a bit presented
      @(negedge clk);
      i_Rst    = 1'b1;
      i_Bit_DV = 1'b1;
      i_Bit    = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_state",  o_State,  0);
      check("midrst_locked", o_Locked, 0);
      @(negedge clk);
      i_Rst    = 1'b0;
      i_Bit_DV = 1'b0;

      // all-ones stream
      do_reset();
      for (int i = 1; i <= 130; i++) begin
         step(1'b1, 1'b1);
         if (i == 127) check("ones_lockup_before", o_Lockup, 0);
      end
      check("ones_lockup", o_Lockup, 1);
      check("ones_count",  o_Err_Count, 0);
      check("ones_locked", o_Locked, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
